// File: rtl/mmio_pkg.sv
// Register map offsets and doorbell FSM encoding for mmio_host_if.
package mmio_pkg;

  localparam logic [7:0] OFF_CMD      = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h01;
  localparam logic [7:0] OFF_ADDR     = 8'h02;
  localparam logic [7:0] OFF_ARG      = 8'h03;
  localparam logic [7:0] OFF_DOORBELL = 8'h04;
  localparam logic [7:0] OFF_MSTAT    = 8'h05;
  localparam logic [7:0] OFF_MMVR     = 8'h10;
  localparam logic [7:0] OFF_RDBUF    = 8'h20;

  typedef enum logic [1:0] {
    StReady,
    StRing,
    StSettle,
    StRdwait
  } db_state_e;

endpackage

// File: rtl/defines.sv
// Command and status encodings shared between the host interface and control_unit.
`ifndef MMIO_DEFINES_SV
`define MMIO_DEFINES_SV

`define HOST_DATA_WIDTH 16

`define CMD_NOP       16'h0000
`define CMD_WRITE_MEM 16'h0001
`define CMD_READ_MEM  16'h0002
`define CMD_RUN       16'h0003

`define STATUS_IDLE   16'h0000
`define STATUS_BUSY   16'h0001
`define STATUS_HALTED 16'h0002

`endif

// File: rtl/mmio_host_if.sv
// Host register file in front of control_unit: builds commands, rings the doorbell,
// assembles the MMVR payload and captures memory read-back data.
`include "defines.sv"

module mmio_host_if
  import mmio_pkg::*;
#(
  parameter int unsigned HOST_DATA_WIDTH = `HOST_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned ARG_WIDTH       = 16,
  parameter int unsigned BUFFER_WIDTH    = 64,
  parameter int unsigned RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 host_addr,
  input  logic                       host_wr_en,
  input  logic [HOST_DATA_WIDTH-1:0] host_wdata,
  input  logic                       host_rd_en,
  output logic [HOST_DATA_WIDTH-1:0] host_rdata,
  output logic                       host_rvalid,
  output logic [HOST_DATA_WIDTH-1:0] cmd_in,
  output logic [ADDR_WIDTH-1:0]      addr_in,
  output logic [ARG_WIDTH-1:0]       arg_in,
  output logic [BUFFER_WIDTH-1:0]    mmvr_in,
  output logic                       doorbell_pulse,
  input  logic [HOST_DATA_WIDTH-1:0] status_out,
  input  logic [BUFFER_WIDTH-1:0]    rd_data_in
);

  localparam int unsigned NChunk = BUFFER_WIDTH / HOST_DATA_WIDTH;
  localparam int unsigned CntW   = $clog2(RD_LATENCY + 1);

  logic [HOST_DATA_WIDTH-1:0] cmd_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ARG_WIDTH-1:0]       arg_q;
  logic [BUFFER_WIDTH-1:0]    mmvr_q;
  logic [BUFFER_WIDTH-1:0]    rdbuf_q;
  logic                       rd_valid_q;
  logic                       drop_err_q;
  logic [CntW-1:0]            cnt_q;
  db_state_e                  state_q;
  logic [HOST_DATA_WIDTH-1:0] rdata_q;
  logic                       rvalid_q;
  logic [HOST_DATA_WIDTH-1:0] rd_mux;

  logic db_wr, db_accept, mstat_wr, fsm_busy;

  assign db_wr     = host_wr_en && (host_addr == OFF_DOORBELL);
  assign mstat_wr  = host_wr_en && (host_addr == OFF_MSTAT);
  assign db_accept = db_wr && (state_q == StReady) &&
                     (status_out != HOST_DATA_WIDTH'(`STATUS_BUSY));
  assign fsm_busy  = (state_q != StReady);

  assign cmd_in      = cmd_q;
  assign addr_in     = addr_q;
  assign arg_in      = arg_q;
  assign mmvr_in     = mmvr_q;
  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      addr_q <= '0;
      arg_q  <= '0;
    end else if (host_wr_en) begin
      if (host_addr == OFF_CMD)  cmd_q  <= host_wdata;
      if (host_addr == OFF_ADDR) addr_q <= host_wdata[ADDR_WIDTH-1:0];
      if (host_addr == OFF_ARG)  arg_q  <= host_wdata[ARG_WIDTH-1:0];
    end
  end

  for (genvar i = 0; i < NChunk; i++) begin : g_mmvr
    localparam logic [7:0] ChunkOff = 8'(OFF_MMVR + i);
    logic [HOST_DATA_WIDTH-1:0] chunk_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        chunk_q <= '0;
      end else if (host_wr_en && (host_addr == ChunkOff)) begin
        chunk_q <= host_wdata;
      end
    end

    assign mmvr_q[i*HOST_DATA_WIDTH +: HOST_DATA_WIDTH] = chunk_q;
  end

  always_comb begin
    rd_mux = '0;
    case (host_addr)
      OFF_CMD:    rd_mux = cmd_q;
      OFF_STATUS: rd_mux = status_out;
      OFF_ADDR:   rd_mux = HOST_DATA_WIDTH'(addr_q);
      OFF_ARG:    rd_mux = HOST_DATA_WIDTH'(arg_q);
      OFF_MSTAT:  rd_mux = HOST_DATA_WIDTH'({fsm_busy, drop_err_q, rd_valid_q});
      default:    rd_mux = '0;
    endcase
    for (int i = 0; i < NChunk; i++) begin
      if (host_addr == 8'(OFF_MMVR + i)) begin
        rd_mux = mmvr_q[i*HOST_DATA_WIDTH +: HOST_DATA_WIDTH];
      end
      if (host_addr == 8'(OFF_RDBUF + i)) begin
        rd_mux = rdbuf_q[i*HOST_DATA_WIDTH +: HOST_DATA_WIDTH];
      end
    end
  end

  // Reads see pre-write values because the mux samples registers before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= host_rd_en;
      if (host_rd_en) rdata_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StReady;
      doorbell_pulse <= 1'b0;
      cnt_q          <= '0;
      rd_valid_q     <= 1'b0;
      drop_err_q     <= 1'b0;
      rdbuf_q        <= '0;
    end else begin
      doorbell_pulse <= 1'b0;
      if (mstat_wr && host_wdata[1]) drop_err_q <= 1'b0;
      if (db_wr && !db_accept)       drop_err_q <= 1'b1;

      unique case (state_q)
        StReady: begin
          if (db_accept) begin
            state_q        <= StRing;
            doorbell_pulse <= 1'b1;
          end
        end
        StRing: begin
          if (cmd_q == HOST_DATA_WIDTH'(`CMD_READ_MEM)) begin
            rd_valid_q <= 1'b0;
            cnt_q      <= CntW'(1);
            state_q    <= StRdwait;
          end else begin
            state_q <= StSettle;
          end
        end
        // Lockout while control_unit moves from IDLE to BUSY.
        StSettle: state_q <= StReady;
        StRdwait: begin
          if (cnt_q == CntW'(RD_LATENCY)) begin
            rdbuf_q    <= rd_data_in;
            rd_valid_q <= 1'b1;
            state_q    <= StReady;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StReady;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_host_if.sv
// Self-checking bench for mmio_host_if: timeline-based reference model plus directed tests.
module tb_mmio_host_if;

  localparam logic [15:0] CMD_WRITE_MEM = 16'h0001;
  localparam logic [15:0] CMD_READ_MEM  = 16'h0002;
  localparam logic [15:0] CMD_RUN       = 16'h0003;
  localparam logic [15:0] ST_IDLE       = 16'h0000;
  localparam logic [15:0] ST_BUSY       = 16'h0001;
  localparam logic [15:0] ST_HALTED     = 16'h0002;
  localparam int RDL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  host_addr;
  logic        host_wr_en, host_rd_en;
  logic [15:0] host_wdata, host_rdata, cmd_in, addr_in, arg_in, status_out;
  logic        host_rvalid, doorbell_pulse;
  logic [63:0] mmvr_in, rd_data_in;

  int checks = 0;
  int errors = 0;

  mmio_host_if dut (
    .clk           (clk),
    .rst           (rst),
    .host_addr     (host_addr),
    .host_wr_en    (host_wr_en),
    .host_wdata    (host_wdata),
    .host_rd_en    (host_rd_en),
    .host_rdata    (host_rdata),
    .host_rvalid   (host_rvalid),
    .cmd_in        (cmd_in),
    .addr_in       (addr_in),
    .arg_in        (arg_in),
    .mmvr_in       (mmvr_in),
    .doorbell_pulse(doorbell_pulse),
    .status_out    (status_out),
    .rd_data_in    (rd_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus a cycle timeline of when the doorbell
  // path is free again, when rd_valid clears and when read-back data is captured.
  logic [15:0] m_cmd, m_addr, m_arg, m_rdata;
  logic [15:0] m_mmvr [4];
  logic [63:0] m_rdbuf;
  logic        m_rdv, m_drop, m_pulse, m_rvalid;
  bit          m_ok = 0;
  int          cyc = 0, ready_at = 0, cap_at = -1, clr_at = -1;

  function automatic logic [15:0] model_read(input logic [7:0] a, input logic busy);
    if (a >= 8'h10 && a < 8'h14) return m_mmvr[a - 8'h10];
    if (a >= 8'h20 && a < 8'h24) return m_rdbuf[(a - 8'h20) * 16 +: 16];
    case (a)
      8'h00:   return m_cmd;
      8'h01:   return status_out;
      8'h02:   return m_addr;
      8'h03:   return m_arg;
      8'h05:   return {13'd0, busy, m_drop, m_rdv};
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    int cur;
    logic ready;
    cur = cyc;
    cyc++;
    if (rst) begin
      m_cmd = '0; m_addr = '0; m_arg = '0; m_rdata = '0;
      for (int i = 0; i < 4; i++) m_mmvr[i] = '0;
      m_rdbuf = '0; m_rdv = 0; m_drop = 0; m_pulse = 0; m_rvalid = 0;
      ready_at = 0; cap_at = -1; clr_at = -1;
      m_ok = 1;
    end else begin
      ready = (cur >= ready_at);
      if (host_rd_en) m_rdata = model_read(host_addr, !ready);
      m_rvalid = host_rd_en;
      m_pulse = 0;
      if (cur == clr_at) m_rdv = 0;
      if (cur == cap_at) begin
        m_rdbuf = rd_data_in;
        m_rdv = 1;
      end
      if (host_wr_en) begin
        if (host_addr >= 8'h10 && host_addr < 8'h14) m_mmvr[host_addr - 8'h10] = host_wdata;
        case (host_addr)
          8'h00: m_cmd = host_wdata;
          8'h02: m_addr = host_wdata;
          8'h03: m_arg = host_wdata;
          8'h04: begin
            if (ready && status_out != ST_BUSY) begin
              m_pulse = 1;
              if (m_cmd == CMD_READ_MEM) begin
                clr_at = cur + 1;
                cap_at = cur + 1 + RDL;
                ready_at = cur + 2 + RDL;
              end else begin
                ready_at = cur + 3;
              end
            end else begin
              m_drop = 1;
            end
          end
          8'h05: if (host_wdata[1]) m_drop = 0;
          default: ;
        endcase
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (m_ok) begin
      check("pulse", doorbell_pulse, m_pulse);
      check("cmd_in", cmd_in, m_cmd);
      check("addr_in", addr_in, m_addr);
      check("arg_in", arg_in, m_arg);
      check("mmvr_in", mmvr_in, {m_mmvr[3], m_mmvr[2], m_mmvr[1], m_mmvr[0]});
      check("rvalid", host_rvalid, m_rvalid);
      check("rdata", host_rdata, m_rdata);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    host_addr = a; host_wdata = d; host_wr_en = 1;
    @(negedge clk);
    host_wr_en = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    host_addr = a; host_rd_en = 1;
    @(negedge clk);
    host_rd_en = 0;
    d = host_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int pulses;
    rst = 1; host_addr = '0; host_wr_en = 0; host_rd_en = 0; host_wdata = '0;
    status_out = ST_IDLE; rd_data_in = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset_pulse", doorbell_pulse, 1'b0);
    check("reset_rvalid", host_rvalid, 1'b0);
    check("reset_rdata", host_rdata, 16'h0);
    check("reset_mmvr", mmvr_in, 64'h0);
    rd(8'h05, d); check("reset_mstat", d, 16'h0000);

    // Write-memory ring with assembled payload
    wr(8'h02, 16'h0040);
    wr(8'h10, 16'h1111); wr(8'h11, 16'h2222); wr(8'h12, 16'h3333); wr(8'h13, 16'h4444);
    wr(8'h00, CMD_WRITE_MEM);
    wr(8'h04, 16'h0000);
    check("t1_pulse", doorbell_pulse, 1'b1);
    check("t1_addr", addr_in, 16'h0040);
    check("t1_mmvr", mmvr_in, 64'h4444_3333_2222_1111);
    check("t1_cmd", cmd_in, CMD_WRITE_MEM);
    @(negedge clk);
    check("t1_pulse_gone", doorbell_pulse, 1'b0);
    rd(8'h02, d); check("addr_rb", d, 16'h0040);
    rd(8'h04, d); check("doorbell_rb", d, 16'h0000);
    rd(8'h7F, d); check("unmapped_rb", d, 16'h0000);
    rd(8'h12, d); check("mmvr2_rb", d, 16'h3333);

    // Ring while busy is dropped
    status_out = ST_BUSY;
    wr(8'h04, 16'h0000);
    check("busy_no_pulse", doorbell_pulse, 1'b0);
    status_out = ST_IDLE;
    rd(8'h05, d); check("busy_mstat", d, 16'h0002);
    wr(8'h05, 16'h0002);
    rd(8'h05, d); check("w1c_mstat", d, 16'h0000);

    // Back-to-back doorbells: second lands in the lockout
    wr(8'h04, 16'h0000);
    pulses = int'(doorbell_pulse);
    wr(8'h04, 16'h0000);
    pulses += int'(doorbell_pulse);
    repeat (4) begin
      @(negedge clk);
      pulses += int'(doorbell_pulse);
    end
    check("b2b_pulses", 64'(pulses), 64'd1);
    rd(8'h05, d); check("b2b_mstat", d, 16'h0002);
    wr(8'h05, 16'h0002);

    // Read-memory ring; data valid only on the capture cycle
    wr(8'h00, CMD_READ_MEM);
    wr(8'h04, 16'h0000);
    check("rd_pulse", doorbell_pulse, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rd_data_in = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1 rd_data_in = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    rd(8'h05, d); check("rd_mstat", d, 16'h0001);
    rd(8'h20, d); check("rdbuf0", d, 16'hF00D);
    rd(8'h21, d); check("rdbuf1", d, 16'hCAFE);
    rd(8'h22, d); check("rdbuf2", d, 16'hBEEF);
    rd(8'h23, d); check("rdbuf3", d, 16'hDEAD);

    // Simultaneous write and read of ARG returns the old value
    host_addr = 8'h03; host_wdata = 16'h0005; host_wr_en = 1; host_rd_en = 1;
    @(negedge clk);
    host_wr_en = 0; host_rd_en = 0;
    check("rw_old", host_rdata, 16'h0000);
    check("rw_new", arg_in, 16'h0005);

    // Ring permitted while halted
    wr(8'h00, CMD_RUN);
    status_out = ST_HALTED;
    wr(8'h04, 16'h0000);
    check("halt_pulse", doorbell_pulse, 1'b1);
    check("halt_arg", arg_in, 16'h0005);
    check("halt_cmd", cmd_in, CMD_RUN);
    status_out = ST_IDLE;
    repeat (3) @(negedge clk);

    // Reset during RDWAIT aborts the capture
    wr(8'h00, CMD_READ_MEM);
    wr(8'h04, 16'h0000);
    check("abort_pulse", doorbell_pulse, 1'b1);
    @(negedge clk);
    rst = 1;
    rd_data_in = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    rst = 0;
    check("abort_cmd", cmd_in, 16'h0);
    check("abort_addr", addr_in, 16'h0);
    check("abort_arg", arg_in, 16'h0);
    check("abort_mmvr", mmvr_in, 64'h0);
    check("abort_pulse0", doorbell_pulse, 1'b0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(doorbell_pulse);
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    rd(8'h20, d); check("abort_rdbuf", d, 16'h0000);
    rd(8'h05, d); check("abort_mstat", d, 16'h0000);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
